perform_nd_writes: RTL and testbench
====================================

Name: perform_nd_writes

Overview:
- Two-level (inner × outer) burst write sequencer.
- Streams data words from a valid/ready source onto the Versat databus as a programmable 2-D pattern: outer_count rows of inner_count bursts, each burst write_length_i beats long.
- Next-generation writer for Versat memory-mapped output units: per-row stride, back-to-back bursts with no idle cycle, and databus handshakes gated to the active state.

Parameters:
- AXI_ADDR_W, 32, databus address width.
- AXI_DATA_W, 32, databus data width (multiple of 8).
- LEN_W, 8, burst length field width.
- COUNT_W, 16, width of inner and outer loop counts.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- run_i  in  1  start pulse; sampled only in IDLE.
- done_o  out  1  high in IDLE.
- inner_count_i  in  COUNT_W  bursts per row.
- outer_count_i  in  COUNT_W  number of rows.
- start_address_i  in  AXI_ADDR_W  first burst address.
- inner_shift_i  in  AXI_ADDR_W  address increment between bursts in a row.
- outer_shift_i  in  AXI_ADDR_W  address increment between row starts.
- write_length_i  in  LEN_W  burst length code driven on databus_len.
- data_valid_i  in  1  source word valid.
- data_ready_o  out  1  source word accepted.
- data_data_i  in  AXI_DATA_W  source word.
- data_last_o  out  1  final beat of whole transfer.
- databus_valid  out  1  bus write valid.
- databus_ready  in  1  bus accepts beat.
- databus_addr  out  AXI_ADDR_W  current burst address.
- databus_wdata  out  AXI_DATA_W  equals data_data_i.
- databus_wstrb  out  AXI_DATA_W/8  all ones.
- databus_len  out  LEN_W  latched write length.
- databus_last  in  1  bus marks last beat of current burst.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE; all counters, address and row_base registers cleared; latched config cleared.
  - Outputs: done_o=1, databus_valid=0, data_ready_o=0, data_last_o=0, databus_addr=0, databus_len=0.
  - Reset mid-burst aborts immediately; no completion signalled.
- States: IDLE, CHECK, BURST.
- IDLE:
  - On run_i=1: latch all config inputs; address<=start_address_i; row_base<=start_address_i; inner_idx<=0; outer_idx<=0; next state CHECK.
  - Config inputs are ignored outside IDLE.
- CHECK (one cycle):
  - inner_count==0 or outer_count==0 -> IDLE (zero-work transfer, no bus activity).
  - Otherwise -> BURST.
- BURST:
  - databus_valid=data_valid_i; data_ready_o=databus_ready. Both are forced 0 in IDLE/CHECK.
  - Beat fires when databus_valid & databus_ready.
  - On a fired beat with databus_last:
    - Not last burst of row (inner_idx != inner_count-1): inner_idx++; address<=address+inner_shift; stay in BURST (no bubble).
    - Last burst of row, not last row: inner_idx<=0; outer_idx++; row_base<=row_base+outer_shift; address<=row_base+outer_shift; stay in BURST.
    - Last burst of last row: -> IDLE.
- data_last_o = fire & databus_last & last inner & last outer; combinational, one cycle.
- done_o rises the cycle after the final beat.
- Arithmetic:
  - All address adds are modulo 2^AXI_ADDR_W; wrap silently.
  - Counter compares use the full COUNT_W width; max 2^COUNT_W-1 per loop.
- run_i held high during operation has no effect. A new run is accepted in the first IDLE cycle after completion.
- Address changes only on a clock edge following the last beat, so databus_addr is stable for the entire burst.

Optional Feature:
- Macro: PERFORM_ND_WRITES_STATUS_EN.
- With the macro defined:
  - Adds output beats_o (32 bits): count of fired beats since last run acceptance, cleared on run acceptance, saturating at all ones.
  - Adds output bursts_o (2*COUNT_W bits): completed bursts since last run acceptance, cleared on run acceptance.
  - Both reset to 0.
- Without the macro: ports and logic absent; all other behaviour identical.

Test Plan:
- Zero-work transfer: inner=4, outer=0, run -> 2 cycles later done_o=1; databus_valid never asserted; data_last_o never pulses.
- 1-D pattern: start=0x1000, inner=3, inner_shift=0x40, outer=1, len=3 (4 beats, last every 4th beat, source always valid, bus always ready) -> addresses 0x1000, 0x1040, 0x1080, 12 beats, no idle cycle between bursts, data_last_o on beat 12, done_o next cycle.
- 2-D pattern: start=0x2000, inner=2, inner_shift=0x10, outer=3, outer_shift=0x100, single-beat bursts -> addresses 0x2000, 0x2010, 0x2100, 0x2110, 0x2200, 0x2210.
- Backpressure: random databus_ready and data_valid_i gaps on the 2-D case -> identical address and data sequence; addr stable within each burst; no beat fires without both valid and ready.
- Wrap and reset: start=0xFFFF_FFF0, inner_shift=0x20, inner=2 -> second burst address 0x0000_0010. Then assert rst_ni low mid-burst -> outputs at reset values, done_o=1, and a subsequent run executes normally.
- Status (macro on): 2-D case, 6 beats -> beats_o=6, bursts_o=6. A new run clears both to 0.

Source files
------------

// File: rtl/perform_nd_writes_if.sv
// Versat databus write channel shared by the N-D write sequencer (master) and the memory unit (slave).
interface perform_nd_writes_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
);
  logic                    databus_valid;
  logic                    databus_ready;
  logic [AXI_ADDR_W-1:0]   databus_addr;
  logic [AXI_DATA_W-1:0]   databus_wdata;
  logic [AXI_DATA_W/8-1:0] databus_wstrb;
  logic [LEN_W-1:0]        databus_len;
  logic                    databus_last;

  modport master (
    output databus_valid, databus_addr, databus_wdata, databus_wstrb, databus_len,
    input  databus_ready, databus_last
  );

  modport slave (
    input  databus_valid, databus_addr, databus_wdata, databus_wstrb, databus_len,
    output databus_ready, databus_last
  );
endinterface

// File: rtl/perform_nd_writes.sv
// Two-level (inner x outer) burst write sequencer streaming source words onto the Versat databus.
// Optional PERFORM_ND_WRITES_STATUS_EN adds beat/burst status counters.
module perform_nd_writes #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8,
  parameter int COUNT_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  run_i,
  output logic                  done_o,
  input  logic [COUNT_W-1:0]    inner_count_i,
  input  logic [COUNT_W-1:0]    outer_count_i,
  input  logic [AXI_ADDR_W-1:0] start_address_i,
  input  logic [AXI_ADDR_W-1:0] inner_shift_i,
  input  logic [AXI_ADDR_W-1:0] outer_shift_i,
  input  logic [LEN_W-1:0]      write_length_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic [AXI_DATA_W-1:0] data_data_i,
  output logic                  data_last_o,
  perform_nd_writes_if.master   bus
`ifdef PERFORM_ND_WRITES_STATUS_EN
  ,
  output logic [31:0]           beats_o,
  output logic [2*COUNT_W-1:0]  bursts_o
`endif
);

  typedef enum logic [1:0] {IDLE, CHECK, BURST} state_e;

  state_e                state_q, state_d;
  logic [COUNT_W-1:0]    inner_cnt_q, inner_cnt_d;
  logic [COUNT_W-1:0]    outer_cnt_q, outer_cnt_d;
  logic [COUNT_W-1:0]    inner_idx_q, inner_idx_d;
  logic [COUNT_W-1:0]    outer_idx_q, outer_idx_d;
  logic [AXI_ADDR_W-1:0] inner_shift_q, inner_shift_d;
  logic [AXI_ADDR_W-1:0] outer_shift_q, outer_shift_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [AXI_ADDR_W-1:0] row_base_q, row_base_d;
  logic [LEN_W-1:0]      len_q, len_d;

  logic accept, fire, burst_end, last_inner, last_outer, zero_work;

  assign accept     = (state_q == IDLE) && run_i;
  assign fire       = (state_q == BURST) && data_valid_i && bus.databus_ready;
  assign burst_end  = fire && bus.databus_last;
  assign last_inner = (inner_idx_q == inner_cnt_q - COUNT_W'(1));
  assign last_outer = (outer_idx_q == outer_cnt_q - COUNT_W'(1));
  assign zero_work  = (inner_cnt_q == '0) || (outer_cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      inner_cnt_q   <= '0;
      outer_cnt_q   <= '0;
      inner_idx_q   <= '0;
      outer_idx_q   <= '0;
      inner_shift_q <= '0;
      outer_shift_q <= '0;
      addr_q        <= '0;
      row_base_q    <= '0;
      len_q         <= '0;
    end else begin
      state_q       <= state_d;
      inner_cnt_q   <= inner_cnt_d;
      outer_cnt_q   <= outer_cnt_d;
      inner_idx_q   <= inner_idx_d;
      outer_idx_q   <= outer_idx_d;
      inner_shift_q <= inner_shift_d;
      outer_shift_q <= outer_shift_d;
      addr_q        <= addr_d;
      row_base_q    <= row_base_d;
      len_q         <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (run_i) state_d = CHECK;
      CHECK:   state_d = zero_work ? IDLE : BURST;
      BURST:   if (burst_end && last_inner && last_outer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every next-state value defaults to its hold value first, so no path infers a latch.
    inner_cnt_d   = inner_cnt_q;
    outer_cnt_d   = outer_cnt_q;
    inner_idx_d   = inner_idx_q;
    outer_idx_d   = outer_idx_q;
    inner_shift_d = inner_shift_q;
    outer_shift_d = outer_shift_q;
    addr_d        = addr_q;
    row_base_d    = row_base_q;
    len_d         = len_q;
    if (accept) begin
      inner_cnt_d   = inner_count_i;
      outer_cnt_d   = outer_count_i;
      inner_shift_d = inner_shift_i;
      outer_shift_d = outer_shift_i;
      len_d         = write_length_i;
      addr_d        = start_address_i;
      row_base_d    = start_address_i;
      inner_idx_d   = '0;
      outer_idx_d   = '0;
    end else if (burst_end) begin
      // Address moves only after the last beat, keeping it stable across the burst.
      if (!last_inner) begin
        inner_idx_d = inner_idx_q + COUNT_W'(1);
        addr_d      = addr_q + inner_shift_q;
      end else if (!last_outer) begin
        inner_idx_d = '0;
        outer_idx_d = outer_idx_q + COUNT_W'(1);
        row_base_d  = row_base_q + outer_shift_q;
        addr_d      = row_base_q + outer_shift_q;
      end
    end
  end

  always_comb begin
    done_o            = (state_q == IDLE);
    bus.databus_valid = (state_q == BURST) && data_valid_i;
    data_ready_o      = (state_q == BURST) && bus.databus_ready;
    data_last_o       = burst_end && last_inner && last_outer;
    bus.databus_addr  = addr_q;
    bus.databus_wdata = data_data_i;
    bus.databus_wstrb = '1;
    bus.databus_len   = len_q;
  end

`ifdef PERFORM_ND_WRITES_STATUS_EN
  logic [31:0]          beats_q;
  logic [2*COUNT_W-1:0] bursts_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beats_q  <= '0;
      bursts_q <= '0;
    end else if (accept) begin
      beats_q  <= '0;
      bursts_q <= '0;
    end else begin
      if (fire && (beats_q != '1)) beats_q <= beats_q + 32'd1;
      if (burst_end) bursts_q <= bursts_q + (2*COUNT_W)'(1);
    end
  end

  assign beats_o  = beats_q;
  assign bursts_o = bursts_q;
`endif

endmodule

// File: tb/tb_perform_nd_writes.sv
// Directed bench for perform_nd_writes: zero-work, 1-D, 2-D, backpressure, wrap and mid-burst reset.
module tb_perform_nd_writes;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        run_i;
  logic        done_o;
  logic [15:0] inner_count_i, outer_count_i;
  logic [31:0] start_address_i, inner_shift_i, outer_shift_i;
  logic [7:0]  write_length_i;
  logic        data_valid_i, data_ready_o, data_last_o;
  logic [31:0] data_data_i;
`ifdef PERFORM_ND_WRITES_STATUS_EN
  logic [31:0] beats_o;
  logic [31:0] bursts_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_addr_q[$];

  always #5 clk_i = ~clk_i;

  perform_nd_writes_if #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .LEN_W(8)) bus_if ();

  perform_nd_writes #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .LEN_W(8), .COUNT_W(16)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .run_i           (run_i),
    .done_o          (done_o),
    .inner_count_i   (inner_count_i),
    .outer_count_i   (outer_count_i),
    .start_address_i (start_address_i),
    .inner_shift_i   (inner_shift_i),
    .outer_shift_i   (outer_shift_i),
    .write_length_i  (write_length_i),
    .data_valid_i    (data_valid_i),
    .data_ready_o    (data_ready_o),
    .data_data_i     (data_data_i),
    .data_last_o     (data_last_o),
    .bus             (bus_if.master)
`ifdef PERFORM_ND_WRITES_STATUS_EN
    ,
    .beats_o         (beats_o),
    .bursts_o        (bursts_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic zero_run(input logic [15:0] inner, input logic [15:0] outer);
    @(negedge clk_i);
    inner_count_i = inner; outer_count_i = outer; start_address_i = 32'h3000;
    run_i = 1'b1; data_valid_i = 1'b1; bus_if.databus_ready = 1'b1; bus_if.databus_last = 1'b1;
    @(negedge clk_i);
    run_i = 1'b0;
    #1;
    check("zero_check_state", {done_o, bus_if.databus_valid, data_last_o}, 3'b000);
    @(negedge clk_i);
    #1;
    check("zero_done", {done_o, bus_if.databus_valid, data_last_o}, 3'b100);
  endtask

  // Runs one transfer against exp_addr_q; abort_after > 0 stops once that many beats were driven.
  task automatic do_run(input logic [31:0] start, input logic [15:0] inner, input logic [15:0] outer,
                        input logic [31:0] ish, input logic [31:0] osh, input logic [7:0] len,
                        input bit bp, input int abort_after);
    int total_beats, k, b, bi, cycles;
    logic vld, rdy;
    total_beats = exp_addr_q.size() * (int'(len) + 1);
    k = 0; b = 0; bi = 0; cycles = 0;
    @(negedge clk_i);
    start_address_i = start; inner_count_i = inner; outer_count_i = outer;
    inner_shift_i = ish; outer_shift_i = osh; write_length_i = len;
    run_i = 1'b1; data_valid_i = 1'b1; bus_if.databus_ready = 1'b1; bus_if.databus_last = 1'b0;
    #1;
    check("idle_gate", {done_o, bus_if.databus_valid, data_ready_o}, 3'b100);
    @(negedge clk_i);
    run_i = 1'b0;
    // Config must be ignored once accepted.
    start_address_i = 32'hDEAD_BEEF; inner_count_i = 16'h0; outer_count_i = 16'h0;
    inner_shift_i = 32'h5; outer_shift_i = 32'h7; write_length_i = 8'h55;
    #1;
    check("check_gate", {done_o, bus_if.databus_valid, data_ready_o}, 3'b000);
`ifdef PERFORM_ND_WRITES_STATUS_EN
    check("status_clear", {beats_o, bursts_o}, 64'd0);
`endif
    while (k < total_beats && cycles < 2000 && !(abort_after > 0 && k >= abort_after)) begin
      @(negedge clk_i);
      cycles++;
      vld = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      data_valid_i = vld;
      bus_if.databus_ready = rdy;
      data_data_i = 32'hD000_0000 + k;
      bus_if.databus_last = (bi == int'(len));
      #1;
      check("handshake_fwd", {bus_if.databus_valid, data_ready_o, done_o}, {vld, rdy, 1'b0});
      if (vld) begin
        check("addr", bus_if.databus_addr, exp_addr_q[b]);
        check("wdata", bus_if.databus_wdata, 32'hD000_0000 + k);
        check("len_strb", {bus_if.databus_len, bus_if.databus_wstrb}, {len, 4'hF});
      end
      check("data_last", data_last_o, (vld && rdy && k == total_beats - 1));
      if (vld && rdy) begin
        k++;
        if (bi == int'(len)) begin bi = 0; b++; end
        else bi++;
      end
    end
    if (abort_after > 0 && k >= abort_after) return;
    check("beats_seen", k, total_beats);
    if (!bp) check("no_bubble_cycles", cycles, total_beats);
    @(negedge clk_i);
    data_valid_i = 1'b1; bus_if.databus_ready = 1'b1; bus_if.databus_last = 1'b1;
    #1;
    check("done_after", {done_o, bus_if.databus_valid, data_ready_o, data_last_o}, 4'b1000);
`ifdef PERFORM_ND_WRITES_STATUS_EN
    check("status_beats", beats_o, total_beats);
    check("status_bursts", bursts_o, exp_addr_q.size());
`endif
  endtask

  initial begin
    rst_ni = 1'b0; run_i = 1'b0;
    inner_count_i = '0; outer_count_i = '0;
    start_address_i = '0; inner_shift_i = '0; outer_shift_i = '0; write_length_i = '0;
    data_valid_i = 1'b1; data_data_i = '0;
    bus_if.databus_ready = 1'b1; bus_if.databus_last = 1'b0;
    #1;
    check("reset_ctrl", {done_o, bus_if.databus_valid, data_ready_o, data_last_o}, 4'b1000);
    check("reset_addr_len", {bus_if.databus_addr, bus_if.databus_len}, 40'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    zero_run(16'd4, 16'd0);
    zero_run(16'd0, 16'd5);

    exp_addr_q = '{32'h1000, 32'h1040, 32'h1080};
    do_run(32'h1000, 16'd3, 16'd1, 32'h40, 32'h0, 8'd3, 1'b0, 0);

    exp_addr_q = '{32'h2000, 32'h2010, 32'h2100, 32'h2110, 32'h2200, 32'h2210};
    do_run(32'h2000, 16'd2, 16'd3, 32'h10, 32'h100, 8'd0, 1'b0, 0);
    do_run(32'h2000, 16'd2, 16'd3, 32'h10, 32'h100, 8'd0, 1'b1, 0);
    do_run(32'h2000, 16'd2, 16'd3, 32'h10, 32'h100, 8'd2, 1'b1, 0);

    exp_addr_q = '{32'hFFFF_FFF0, 32'h0000_0010};
    do_run(32'hFFFF_FFF0, 16'd2, 16'd1, 32'h20, 32'h0, 8'd3, 1'b0, 6);
    #2;
    rst_ni = 1'b0;
    #1;
    check("abort_ctrl", {done_o, bus_if.databus_valid, data_ready_o, data_last_o}, 4'b1000);
    check("abort_addr_len", {bus_if.databus_addr, bus_if.databus_len}, 40'd0);
`ifdef PERFORM_ND_WRITES_STATUS_EN
    check("abort_status", {beats_o, bursts_o}, 64'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;

    exp_addr_q = '{32'h2000, 32'h2010, 32'h2100, 32'h2110, 32'h2200, 32'h2210};
    do_run(32'h2000, 16'd2, 16'd3, 32'h10, 32'h100, 8'd0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
